// File: rtl/apb_bridge_pkg.sv
// Shared types and defaults for the APB side of the AHB-to-APB bridge:
// sequencer state encoding, slave address map and the default-map decode.
package apb_bridge_pkg;

    localparam int          DEF_ADDR_W   = 32;
    localparam int          DEF_DATA_W   = 32;
    localparam int          DEF_NUM_SLV  = 3;
    localparam logic [31:0] DEF_SLV_BASE = 32'h8000_0000;
    localparam logic [31:0] DEF_SLV_SIZE = 32'h0400_0000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_READ     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WRITEP   = 3'd4,
        ST_RENABLE  = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } state_e;

    function automatic logic is_setup(input state_e s);
        return (s == ST_READ) || (s == ST_WRITE) || (s == ST_WRITEP);
    endfunction

    function automatic logic is_enable(input state_e s);
        return (s == ST_RENABLE) || (s == ST_WENABLE) || (s == ST_WENABLEP);
    endfunction

    // One-hot select for the default address map; zero outside every window.
    function automatic logic [DEF_NUM_SLV-1:0] sel_decode(input logic [DEF_ADDR_W-1:0] addr);
        logic [DEF_NUM_SLV-1:0] sel;
        logic [DEF_ADDR_W:0]    lo;
        logic [DEF_ADDR_W:0]    a;
        sel = '0;
        a   = {1'b0, addr};
        for (int k = 0; k < DEF_NUM_SLV; k++) begin
            lo     = {1'b0, DEF_SLV_BASE} + (DEF_ADDR_W + 1)'(k) * {1'b0, DEF_SLV_SIZE};
            sel[k] = (a >= lo) && (a < lo + {1'b0, DEF_SLV_SIZE});
        end
        return sel;
    endfunction

endpackage

// File: rtl/apb_sel_decode.sv
// Combinational address-to-Pselx decode over NUM_SLV contiguous windows.
module apb_sel_decode
    import apb_bridge_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                NUM_SLV  = DEF_NUM_SLV,
    parameter logic [ADDR_W-1:0] SLV_BASE = ADDR_W'(DEF_SLV_BASE),
    parameter logic [ADDR_W-1:0] SLV_SIZE = ADDR_W'(DEF_SLV_SIZE)
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [NUM_SLV-1:0] pselx
);

    localparam bit IS_DEFAULT_MAP = (ADDR_W == DEF_ADDR_W) && (NUM_SLV == DEF_NUM_SLV) &&
                                    (SLV_BASE == DEF_SLV_BASE) && (SLV_SIZE == DEF_SLV_SIZE);

    if (IS_DEFAULT_MAP) begin : g_default
        assign pselx = sel_decode(addr);
    end else begin : g_generic
        // Window bounds are widened to 64 bits so the last window cannot wrap.
        for (genvar k = 0; k < NUM_SLV; k++) begin : g_win
            localparam logic [63:0] LO = 64'(SLV_BASE) + 64'(k) * 64'(SLV_SIZE);
            localparam logic [63:0] HI = LO + 64'(SLV_SIZE);
            assign pselx[k] = (64'(addr) >= LO) && (64'(addr) < HI);
        end
    end

endmodule

// File: rtl/apb_fsm_controller.sv
// APB-side sequencer of the AHB-to-APB bridge: turns qualified AHB transfers
// into APB SETUP/ENABLE cycles and stalls AHB via Hreadyout while busy.
module apb_fsm_controller
    import apb_bridge_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                NUM_SLV  = DEF_NUM_SLV,
    parameter logic [ADDR_W-1:0] SLV_BASE = ADDR_W'(DEF_SLV_BASE),
    parameter logic [ADDR_W-1:0] SLV_SIZE = ADDR_W'(DEF_SLV_SIZE)
) (
    input  logic               Hclk,
    input  logic               Hresetn,
    input  logic               valid,
    input  logic               Hwrite,
    input  logic               Hwritereg,
    input  logic [ADDR_W-1:0]  Haddr,
    input  logic [ADDR_W-1:0]  Haddr1,
    input  logic [ADDR_W-1:0]  Haddr2,
    input  logic [DATA_W-1:0]  Hwdata,
    input  logic [DATA_W-1:0]  Hwdata1,
    output logic               Pwrite,
    output logic               Penable,
    output logic [NUM_SLV-1:0] Pselx,
    output logic [ADDR_W-1:0]  Paddr,
    output logic [DATA_W-1:0]  Pwdata,
    output logic               Hreadyout
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d;
    logic                penable_q, penable_d;
    logic [NUM_SLV-1:0]  pselx_q, pselx_d;
    logic                hreadyout_q, hreadyout_d;
    logic [NUM_SLV-1:0]  sel_next;

    // Next state plus the address/data captured on entry to a setup state.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;

        unique case (state_q)
            ST_IDLE:     if (valid) state_d = Hwrite ? ST_WWAIT : ST_READ;
            ST_WWAIT:    state_d = valid ? ST_WRITEP : ST_WRITE;
            ST_READ:     state_d = ST_RENABLE;
            ST_WRITE:    state_d = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP:   state_d = ST_WENABLEP;
            ST_RENABLE,
            ST_WENABLE:  state_d = !valid ? ST_IDLE : (Hwrite ? ST_WWAIT : ST_READ);
            ST_WENABLEP: state_d = !Hwritereg ? ST_READ : (valid ? ST_WRITEP : ST_WRITE);
            default:     state_d = ST_IDLE;
        endcase

        // A write issued straight after a pipelined enable is one AHB stage older.
        if (state_d == ST_READ) begin
            paddr_d = Haddr;
        end else if ((state_d == ST_WRITE) || (state_d == ST_WRITEP)) begin
            if (state_q == ST_WENABLEP) begin
                paddr_d  = Haddr2;
                pwdata_d = Hwdata1;
            end else begin
                paddr_d  = Haddr1;
                pwdata_d = Hwdata;
            end
        end
    end

    apb_sel_decode #(
        .ADDR_W   (ADDR_W),
        .NUM_SLV  (NUM_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_SIZE (SLV_SIZE)
    ) u_sel_decode (
        .addr  (paddr_d),
        .pselx (sel_next)
    );

    // Outputs are a function of the state being entered, so they register alongside it.
    always_comb begin
        pwrite_d    = pwrite_q;
        pselx_d     = pselx_q;
        penable_d   = 1'b0;
        hreadyout_d = 1'b1;
        if (is_setup(state_d)) begin
            pselx_d     = sel_next;
            pwrite_d    = (state_d != ST_READ);
            hreadyout_d = 1'b0;
        end else if (is_enable(state_d)) begin
            penable_d   = 1'b1;
        end else begin
            pselx_d     = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            penable_q   <= 1'b0;
            pselx_q     <= '0;
            hreadyout_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            penable_q   <= penable_d;
            pselx_q     <= pselx_d;
            hreadyout_q <= hreadyout_d;
        end
    end

    assign Pwrite    = pwrite_q;
    assign Penable   = penable_q;
    assign Pselx     = pselx_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign Hreadyout = hreadyout_q;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for apb_fsm_controller; the AHB pipeline delays are modelled
// here and every output is compared against hand-computed snapshots.
module tb_apb_fsm_controller;

    logic        Hclk = 1'b0;
    logic        Hresetn = 1'b0;
    logic        valid = 1'b0;
    logic        Hwrite = 1'b0;
    logic        Hwritereg = 1'b0;
    logic [31:0] Haddr = '0, Haddr1 = '0, Haddr2 = '0;
    logic [31:0] Hwdata = '0, Hwdata1 = '0;
    logic        Pwrite, Penable, Hreadyout;
    logic [2:0]  Pselx;
    logic [31:0] Paddr, Pwdata;

    int checks = 0;
    int fails  = 0;

    // {valid, Hwrite, Haddr, Hwdata} driven before an edge, expected outputs after it.
    typedef struct packed {
        logic        v;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [69:0] exp;
    } vec_t;

    apb_fsm_controller dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .valid     (valid),
        .Hwrite    (Hwrite),
        .Hwritereg (Hwritereg),
        .Haddr     (Haddr),
        .Haddr1    (Haddr1),
        .Haddr2    (Haddr2),
        .Hwdata    (Hwdata),
        .Hwdata1   (Hwdata1),
        .Pwrite    (Pwrite),
        .Penable   (Penable),
        .Pselx     (Pselx),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Hreadyout (Hreadyout)
    );

    always #5 Hclk = ~Hclk;

    always @(posedge Hclk) begin
        Haddr1    <= Haddr;
        Haddr2    <= Haddr1;
        Hwdata1   <= Hwdata;
        Hwritereg <= Hwrite;
    end

    // Snapshot layout: {Pwrite, Penable, Pselx, Hreadyout, Paddr, Pwdata}.
    function automatic logic [69:0] snap();
        return {Pwrite, Penable, Pselx, Hreadyout, Paddr, Pwdata};
    endfunction

    localparam logic [69:0] RESET_SNAP = {1'b0, 1'b0, 3'b000, 1'b1, 32'h0, 32'h0};

    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    // Protocol invariants watched on every falling edge once reset has been applied.
    logic        mon_en = 1'b0;
    logic        prev_pen = 1'b0, prev_hrdy = 1'b1;
    logic [2:0]  prev_sel = '0;
    logic [31:0] prev_addr = '0;

    always @(negedge Hclk) begin
        if (mon_en) begin
            checks++;
            if ($onehot0(Pselx) !== 1'b1) begin
                fails++;
                $display("FAIL pselx_onehot0: Pselx=%b is not one-hot or zero", Pselx);
            end
            if (Penable === 1'b1) begin
                checks++;
                if (prev_pen || prev_hrdy || (prev_addr !== Paddr) || (prev_sel !== Pselx)) begin
                    fails++;
                    $display("FAIL enable_after_setup: prev pen=%b hrdy=%b addr=%h sel=%b, now addr=%h sel=%b",
                             prev_pen, prev_hrdy, prev_addr, prev_sel, Paddr, Pselx);
                end
            end
            prev_pen  = Penable;
            prev_hrdy = Hreadyout;
            prev_sel  = Pselx;
            prev_addr = Paddr;
        end
    end

    task automatic test_reset();
        Hresetn = 1'b0;
        valid   = 1'b0;
        repeat (2) step();
        checks++;
        if (snap() !== RESET_SNAP) begin
            fails++;
            $display("FAIL reset_values: got %h expected %h", snap(), RESET_SNAP);
        end
        Hresetn = 1'b1;
        mon_en  = 1'b1;
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (snap() !== RESET_SNAP) begin
                fails++;
                $display("FAIL idle_hold[%0d]: got %h expected %h", i, snap(), RESET_SNAP);
            end
        end
    endtask

    task automatic test_single_read();
        vec_t tbl [3];
        tbl = '{
            '{1'b1, 1'b0, 32'h8000_0010, 32'h0, {1'b0, 1'b0, 3'b001, 1'b0, 32'h8000_0010, 32'h0}},
            '{1'b0, 1'b0, 32'h8000_0010, 32'h0, {1'b0, 1'b1, 3'b001, 1'b1, 32'h8000_0010, 32'h0}},
            '{1'b0, 1'b0, 32'h8000_0010, 32'h0, {1'b0, 1'b0, 3'b000, 1'b1, 32'h8000_0010, 32'h0}}
        };
        for (int i = 0; i < 3; i++) begin
            valid = tbl[i].v; Hwrite = tbl[i].w; Haddr = tbl[i].a; Hwdata = tbl[i].d;
            step();
            checks++;
            if (snap() !== tbl[i].exp) begin
                fails++;
                $display("FAIL single_read[%0d]: got %h expected %h", i, snap(), tbl[i].exp);
            end
        end
    endtask

    task automatic test_single_write();
        vec_t tbl [4];
        tbl = '{
            '{1'b1, 1'b1, 32'h8400_0004, 32'h0,         {1'b0, 1'b0, 3'b000, 1'b1, 32'h8000_0010, 32'h0}},
            '{1'b0, 1'b0, 32'h0,         32'hDEAD_BEEF, {1'b1, 1'b0, 3'b010, 1'b0, 32'h8400_0004, 32'hDEAD_BEEF}},
            '{1'b0, 1'b0, 32'h0,         32'hDEAD_BEEF, {1'b1, 1'b1, 3'b010, 1'b1, 32'h8400_0004, 32'hDEAD_BEEF}},
            '{1'b0, 1'b0, 32'h0,         32'h0,         {1'b1, 1'b0, 3'b000, 1'b1, 32'h8400_0004, 32'hDEAD_BEEF}}
        };
        for (int i = 0; i < 4; i++) begin
            valid = tbl[i].v; Hwrite = tbl[i].w; Haddr = tbl[i].a; Hwdata = tbl[i].d;
            step();
            checks++;
            if (snap() !== tbl[i].exp) begin
                fails++;
                $display("FAIL single_write[%0d]: got %h expected %h", i, snap(), tbl[i].exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t tbl [6];
        tbl = '{
            '{1'b1, 1'b1, 32'h8800_0000, 32'h0, {1'b1, 1'b0, 3'b000, 1'b1, 32'h8400_0004, 32'hDEAD_BEEF}},
            '{1'b1, 1'b1, 32'h8800_0004, 32'h1, {1'b1, 1'b0, 3'b100, 1'b0, 32'h8800_0000, 32'h1}},
            '{1'b0, 1'b1, 32'h8800_0004, 32'h2, {1'b1, 1'b1, 3'b100, 1'b1, 32'h8800_0000, 32'h1}},
            '{1'b0, 1'b0, 32'h8800_0004, 32'h2, {1'b1, 1'b0, 3'b100, 1'b0, 32'h8800_0004, 32'h2}},
            '{1'b0, 1'b0, 32'h0,         32'h0, {1'b1, 1'b1, 3'b100, 1'b1, 32'h8800_0004, 32'h2}},
            '{1'b0, 1'b0, 32'h0,         32'h0, {1'b1, 1'b0, 3'b000, 1'b1, 32'h8800_0004, 32'h2}}
        };
        for (int i = 0; i < 6; i++) begin
            valid = tbl[i].v; Hwrite = tbl[i].w; Haddr = tbl[i].a; Hwdata = tbl[i].d;
            step();
            checks++;
            if (snap() !== tbl[i].exp) begin
                fails++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, snap(), tbl[i].exp);
            end
        end
    endtask

    task automatic test_write_then_read();
        vec_t tbl [6];
        tbl = '{
            '{1'b1, 1'b1, 32'h8000_0100, 32'h0,         {1'b1, 1'b0, 3'b000, 1'b1, 32'h8800_0004, 32'h2}},
            '{1'b1, 1'b0, 32'h8000_0020, 32'h5555_AAAA, {1'b1, 1'b0, 3'b001, 1'b0, 32'h8000_0100, 32'h5555_AAAA}},
            '{1'b0, 1'b0, 32'h8000_0020, 32'h0,         {1'b1, 1'b1, 3'b001, 1'b1, 32'h8000_0100, 32'h5555_AAAA}},
            '{1'b0, 1'b0, 32'h8000_0020, 32'h0,         {1'b0, 1'b0, 3'b001, 1'b0, 32'h8000_0020, 32'h5555_AAAA}},
            '{1'b0, 1'b0, 32'h0,         32'h0,         {1'b0, 1'b1, 3'b001, 1'b1, 32'h8000_0020, 32'h5555_AAAA}},
            '{1'b0, 1'b0, 32'h0,         32'h0,         {1'b0, 1'b0, 3'b000, 1'b1, 32'h8000_0020, 32'h5555_AAAA}}
        };
        for (int i = 0; i < 6; i++) begin
            valid = tbl[i].v; Hwrite = tbl[i].w; Haddr = tbl[i].a; Hwdata = tbl[i].d;
            step();
            checks++;
            if (snap() !== tbl[i].exp) begin
                fails++;
                $display("FAIL write_then_read[%0d]: got %h expected %h", i, snap(), tbl[i].exp);
            end
        end
    endtask

    task automatic test_decode_boundary();
        logic [31:0] addrs [5];
        logic [2:0]  sels  [5];
        logic [69:0] exp;
        addrs = '{32'h87FF_FFFC, 32'h8C00_0000, 32'h7FFF_FFFF, 32'h8BFF_FFFF, 32'h8400_0000};
        sels  = '{3'b010,        3'b000,        3'b000,        3'b100,        3'b010};
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1; Hwrite = 1'b0; Haddr = addrs[i];
            step();
            exp = {1'b0, 1'b0, sels[i], 1'b0, addrs[i], 32'h5555_AAAA};
            checks++;
            if (snap() !== exp) begin
                fails++;
                $display("FAIL decode_setup[%0d]: got %h expected %h", i, snap(), exp);
            end
            valid = 1'b0;
            step();
            exp = {1'b0, 1'b1, sels[i], 1'b1, addrs[i], 32'h5555_AAAA};
            checks++;
            if (snap() !== exp) begin
                fails++;
                $display("FAIL decode_enable[%0d]: got %h expected %h", i, snap(), exp);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_op();
        logic [69:0] exp;
        valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8400_0040; Hwdata = 32'h0;
        step();
        Haddr = 32'h8400_0044; Hwdata = 32'h77;
        step();
        exp = {1'b1, 1'b0, 3'b010, 1'b0, 32'h8400_0040, 32'h77};
        checks++;
        if (snap() !== exp) begin
            fails++;
            $display("FAIL mid_op_writep: got %h expected %h", snap(), exp);
        end
        Hresetn = 1'b0;
        step();
        checks++;
        if (snap() !== RESET_SNAP) begin
            fails++;
            $display("FAIL mid_op_reset: got %h expected %h", snap(), RESET_SNAP);
        end
        Hresetn = 1'b1; valid = 1'b0; Hwrite = 1'b0; Haddr = 32'h0; Hwdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (snap() !== RESET_SNAP) begin
                fails++;
                $display("FAIL post_reset_quiet[%0d]: got %h expected %h", i, snap(), RESET_SNAP);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_write_then_read();
        test_decode_boundary();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded 50000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_fsm_controller.md
Name: apb_fsm_controller

Overview:
APB-side sequencer of the AHB-to-APB bridge.
- Consumes the qualified transfer strobe and the pipelined address/data/control from the AHB slave interface.
- Drives the APB SETUP/ENABLE protocol to three peripherals.
- Returns Hreadyout to insert AHB wait states while an APB access is in progress.
- Supports single reads, single writes and back-to-back (pipelined) writes.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- NUM_SLV, 3, number of APB slaves; width of Pselx.
- SLV_BASE, 32'h8000_0000, base of slave 0.
- SLV_SIZE, 32'h0400_0000, address window per slave, contiguous.

Ports:
- Hclk  in  1  bridge clock.
- Hresetn  in  1  synchronous, active-low reset.
- valid  in  1  qualified AHB transfer in the current address phase.
- Hwrite  in  1  current address-phase direction.
- Hwritereg  in  1  Hwrite delayed one cycle.
- Haddr  in  ADDR_W  current address-phase address.
- Haddr1  in  ADDR_W  Haddr delayed 1 cycle.
- Haddr2  in  ADDR_W  Haddr delayed 2 cycles.
- Hwdata  in  DATA_W  current AHB write data.
- Hwdata1  in  DATA_W  Hwdata delayed 1 cycle.
- Pwrite  out  1  APB direction.
- Penable  out  1  APB enable.
- Pselx  out  NUM_SLV  one-hot APB select.
- Paddr  out  ADDR_W  APB address.
- Pwdata  out  DATA_W  APB write data.
- Hreadyout  out  1  AHB ready; 0 inserts a wait state.

Behaviour:
- Clocking and reset: single clock Hclk. Reset is synchronous and active-low on Hresetn.
- Reset values: state ST_IDLE; Pwrite, Penable, Pselx, Paddr, Pwdata = 0; Hreadyout = 1.
- Reset mid-transfer: aborts the transfer; all outputs take their reset values on the next edge, with no ENABLE cycle issued.
- Output timing: all outputs registered. Each output's value is a function of the state being entered, so it appears in the same cycle as that state.
- States and transitions (evaluated each Hclk edge):
  - ST_IDLE: valid&Hwrite -> ST_WWAIT; valid&~Hwrite -> ST_READ; else stay.
  - ST_WWAIT: valid -> ST_WRITEP; else -> ST_WRITE.
  - ST_READ: -> ST_RENABLE, unconditional.
  - ST_WRITE: valid -> ST_WENABLEP; else -> ST_WENABLE.
  - ST_WRITEP: -> ST_WENABLEP, unconditional.
  - ST_RENABLE and ST_WENABLE: valid&~Hwrite -> ST_READ; valid&Hwrite -> ST_WWAIT; else -> ST_IDLE.
  - ST_WENABLEP: ~Hwritereg -> ST_READ; valid&Hwritereg -> ST_WRITEP; ~valid&Hwritereg -> ST_WRITE.
- Setup states (ST_READ, ST_WRITE, ST_WRITEP):
  - Penable=0; Pselx=decode(Paddr); Hreadyout=0.
  - Pwrite=0 in ST_READ, 1 otherwise.
- Enable states (ST_RENABLE, ST_WENABLE, ST_WENABLEP):
  - Paddr, Pwdata, Pselx, Pwrite held from the preceding setup cycle.
  - Penable=1; Hreadyout=1.
- ST_IDLE and ST_WWAIT: Pselx=0; Penable=0; Hreadyout=1; Paddr and Pwdata hold their last values.
- Address/data sources when entering a setup state:
  - ST_READ: Paddr=Haddr.
  - ST_WRITE or ST_WRITEP from ST_WWAIT: Paddr=Haddr1, Pwdata=Hwdata.
  - ST_WRITE or ST_WRITEP from ST_WENABLEP: Paddr=Haddr2, Pwdata=Hwdata1.
- Decode:
  - Slave k is selected iff SLV_BASE + k*SLV_SIZE <= addr < SLV_BASE + (k+1)*SLV_SIZE.
  - Out-of-window addresses give Pselx=0. The FSM still sequences normally; upstream valid normally prevents this case.
- Invariants:
  - Penable=1 only in the cycle after a setup cycle with identical Paddr and Pselx.
  - Pselx is always one-hot or zero.
  - No two consecutive cycles have Penable=1.
- Latency: every APB access is 2 cycles (setup + enable). A single write spends 1 extra cycle in ST_WWAIT collecting the AHB data phase.

Decomposition:
- Package apb_bridge_pkg holds:
  - the state enum (3-bit encoding, ST_IDLE=0);
  - the SLV_BASE/SLV_SIZE defaults;
  - function sel_decode(addr) returning NUM_SLV bits.
- One sub-module, apb_sel_decode: purely combinational address-to-Pselx decode, instantiated on the next-Paddr value.

Test Plan:
1. Single read: valid=1, Hwrite=0, Haddr=32'h8000_0010 in ST_IDLE.
   - Next cycle: Paddr=32'h8000_0010, Pselx=001, Pwrite=0, Penable=0, Hreadyout=0.
   - Following cycle: Penable=1, Hreadyout=1.
   - Then ST_IDLE with Pselx=0.
2. Single write: valid, Hwrite=1, Haddr=32'h8400_0004, then Hwdata=32'hDEAD_BEEF with valid=0.
   - Sequence ST_WWAIT -> ST_WRITE -> ST_WENABLE.
   - Paddr=32'h8400_0004, Pwdata=32'hDEAD_BEEF, Pselx=010, Pwrite=1; Penable high exactly 1 cycle.
3. Back-to-back writes to 32'h8800_0000 then 32'h8800_0004, data 32'h1 then 32'h2.
   - Path ST_WWAIT -> ST_WRITEP -> ST_WENABLEP -> ST_WRITE -> ST_WENABLE.
   - Two APB writes in order with Pselx=100 and correct address/data pairing.
4. Write followed by read to 32'h8000_0020.
   - From ST_WENABLEP with Hwritereg=0, next state ST_READ.
   - Paddr=32'h8000_0020, Pwrite=0.
5. Reset mid-op: Hresetn=0 during ST_WRITEP.
   - Next edge: all outputs 0, Hreadyout=1, state ST_IDLE.
   - No Penable pulse after release until a new valid.
6. Idle hold: valid=0 for 10 cycles from reset.
   - Pselx=0, Penable=0, Hreadyout=1 throughout; Paddr stays 0.
